// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared constants, requester enum and writeback record for the writeback port arbiter
package wb_pkg;

    localparam int WB_XLEN = 32;
    localparam int WB_AW   = 5;
    localparam int WB_NREG = 2 ** WB_AW;

    // Identifies which requester owns the register file write port.
    typedef enum logic [0:0] {
        REQ_ALU = 1'b0,
        REQ_LSU = 1'b1
    } req_e;

    // One registered write into the register file.
    typedef struct packed {
        logic               we;
        logic [WB_AW-1:0]   waddr;
        logic [WB_XLEN-1:0] wdata;
    } wb_rec_t;

endpackage

// File: rtl/wb_scoreboard.sv
// rtl/wb_scoreboard.sv - per-register pending-write busy bits with RAW/WAW hazard lookups
module wb_scoreboard
    import wb_pkg::*;
#(
    parameter int AW   = WB_AW,
    parameter int NREG = 2 ** AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          set_valid,
    input  logic [AW-1:0] set_addr,
    input  logic          clr_valid,
    input  logic [AW-1:0] clr_addr,
    input  logic [AW-1:0] rs1,
    input  logic [AW-1:0] rs2,
    input  logic [AW-1:0] rd_chk,
    output logic          hazard_rs1,
    output logic          hazard_rs2,
    output logic          rd_busy
);

    // Register 0 is never tracked; it reads as idle through busy_vec.
    logic [NREG-1:1] busy_q;
    logic [NREG-1:1] busy_d;
    logic [NREG-1:0] busy_vec;

    assign busy_vec = {busy_q, 1'b0};

    // Clear on a committing write, then set on issue so a same-cycle set wins.
    always_comb begin
        busy_d = busy_q;
        for (int r = 1; r < NREG; r++) begin
            if (clr_valid && (clr_addr == AW'(r))) begin
                busy_d[r] = 1'b0;
            end
            if (set_valid && (set_addr == AW'(r))) begin
                busy_d[r] = 1'b1;
            end
        end
    end

    // Busy-bit storage.
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign hazard_rs1 = busy_vec[rs1];
    assign hazard_rs2 = busy_vec[rs2];
    assign rd_busy    = busy_vec[rd_chk];

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - ALU/LSU writeback arbiter with registered RF write stage; WB_ROUND_ROBIN_EN selects round-robin contention
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int XLEN = WB_XLEN,
    parameter int AW   = WB_AW,
    parameter int NREG = 2 ** AW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            alu_valid,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            lsu_valid,
    input  logic [AW-1:0]   lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            lsu_ready,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic            hazard_rs1,
    output logic            hazard_rs2,
    output logic            issue_stall,
    output logic            rf_we,
    output logic [AW-1:0]   rf_waddr,
    output logic [XLEN-1:0] rf_wdata
);

    logic    both_valid;
    req_e    winner;
    wb_rec_t wb_q;
    wb_rec_t wb_d;

    assign both_valid = alu_valid && lsu_valid;

`ifdef WB_ROUND_ROBIN_EN
    req_e last_q;
    req_e last_d;

    // Contended grant goes to whoever did not win the previous contention.
    always_comb begin
        winner = (last_q == REQ_LSU) ? REQ_ALU : REQ_LSU;
        last_d = last_q;
        if (reset && both_valid) begin
            last_d = winner;
        end
    end

    // Pointer resets as if the ALU won last, so LSU is preferred first.
    always_ff @(posedge clk) begin
        if (!reset) begin
            last_q <= REQ_ALU;
        end else begin
            last_q <= last_d;
        end
    end
`else
    // Fixed priority: the load unit always wins a contended cycle.
    always_comb begin
        winner = REQ_LSU;
    end
`endif

    // Grant: a lone requester is taken immediately; contention uses the winner.
    always_comb begin
        alu_ready = 1'b0;
        lsu_ready = 1'b0;
        if (reset) begin
            if (both_valid) begin
                alu_ready = (winner == REQ_ALU);
                lsu_ready = (winner == REQ_LSU);
            end else begin
                alu_ready = alu_valid;
                lsu_ready = lsu_valid;
            end
        end
    end

    // Output stage next value; x0 writes are accepted but never enable the RF.
    always_comb begin
        wb_d    = wb_q;
        wb_d.we = 1'b0;
        if (lsu_ready) begin
            wb_d.we    = (lsu_rd != '0);
            wb_d.waddr = lsu_rd;
            wb_d.wdata = lsu_data;
        end else if (alu_ready) begin
            wb_d.we    = (alu_rd != '0);
            wb_d.waddr = alu_rd;
            wb_d.wdata = alu_data;
        end
    end

    // Registered register-file write port.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wb_q <= '0;
        end else begin
            wb_q <= wb_d;
        end
    end

    assign rf_we    = wb_q.we;
    assign rf_waddr = wb_q.waddr;
    assign rf_wdata = wb_q.wdata;

    // Busy bits clear only when the write actually commits from the output stage.
    wb_scoreboard #(
        .AW   (AW),
        .NREG (NREG)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .set_valid  (issue_valid),
        .set_addr   (issue_rd),
        .clr_valid  (wb_q.we),
        .clr_addr   (wb_q.waddr),
        .rs1        (rs1),
        .rs2        (rs2),
        .rd_chk     (issue_rd),
        .hazard_rs1 (hazard_rs1),
        .hazard_rs2 (hazard_rs2),
        .rd_busy    (issue_stall)
    );

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - self-checking bench for wb_port_arbiter against a behavioural model
module tb_wb_port_arbiter;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic            alu_valid, lsu_valid, issue_valid;
    logic [AW-1:0]   alu_rd, lsu_rd, issue_rd, rs1, rs2;
    logic [XLEN-1:0] alu_data, lsu_data;
    logic            alu_ready, lsu_ready;
    logic            hazard_rs1, hazard_rs2, issue_stall;
    logic            rf_we;
    logic [AW-1:0]   rf_waddr;
    logic [XLEN-1:0] rf_wdata;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state.
    bit            mdl_busy [32];
    bit            mdl_we;
    logic [AW-1:0] mdl_waddr;
    logic [31:0]   mdl_wdata;
    bit            mdl_prefer_alu;

    always #5 clk = ~clk;

    wb_port_arbiter #(.XLEN(XLEN), .AW(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .alu_ready   (alu_ready),
        .lsu_valid   (lsu_valid),
        .lsu_rd      (lsu_rd),
        .lsu_data    (lsu_data),
        .lsu_ready   (lsu_ready),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .hazard_rs1  (hazard_rs1),
        .hazard_rs2  (hazard_rs2),
        .issue_stall (issue_stall),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata)
    );

    // Who should be granted given the present inputs.
    task automatic model_grant(output bit ga, output bit gl);
        ga = 1'b0;
        gl = 1'b0;
        if (reset === 1'b1) begin
            if (alu_valid && lsu_valid) begin
`ifdef WB_ROUND_ROBIN_EN
                ga = mdl_prefer_alu;
                gl = !mdl_prefer_alu;
`else
                gl = 1'b1;
`endif
            end else begin
                ga = alu_valid;
                gl = lsu_valid;
            end
        end
    endtask

    // Advance the model by one clock using the inputs present before the edge.
    task automatic mdl_step();
        bit ga, gl;
        if (reset !== 1'b1) begin
            foreach (mdl_busy[r]) mdl_busy[r] = 1'b0;
            mdl_we         = 1'b0;
            mdl_waddr      = '0;
            mdl_wdata      = '0;
            mdl_prefer_alu = 1'b0;
        end else begin
            model_grant(ga, gl);
            if (mdl_we) mdl_busy[mdl_waddr] = 1'b0;
            if (issue_valid && issue_rd != 0) mdl_busy[issue_rd] = 1'b1;
            if (alu_valid && lsu_valid) mdl_prefer_alu = !mdl_prefer_alu;
            if (gl) begin
                mdl_we = (lsu_rd != 0); mdl_waddr = lsu_rd; mdl_wdata = lsu_data;
            end else if (ga) begin
                mdl_we = (alu_rd != 0); mdl_waddr = alu_rd; mdl_wdata = alu_data;
            end else begin
                mdl_we = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        mdl_step();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
        lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h22;
        issue_valid = 1'b0; issue_rd = 5'd6; rs1 = 5'd7; rs2 = 5'd8;
        tick();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_cmp++;
            if (rf_we !== 1'b0 || rf_waddr !== '0 || rf_wdata !== '0) begin
                n_err++;
                $display("FAIL reset_out: we=%b waddr=%0d wdata=%h required 0/0/0", rf_we, rf_waddr, rf_wdata);
            end
            n_cmp++;
            if (alu_ready !== 1'b0 || lsu_ready !== 1'b0) begin
                n_err++;
                $display("FAIL reset_ready: alu=%b lsu=%b required 0/0", alu_ready, lsu_ready);
            end
            n_cmp++;
            if (hazard_rs1 !== 1'b0 || hazard_rs2 !== 1'b0 || issue_stall !== 1'b0) begin
                n_err++;
                $display("FAIL reset_hazard: %b%b%b required 000", hazard_rs1, hazard_rs2, issue_stall);
            end
            tick();
        end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (lsu_ready !== 1'b1 || alu_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_first_grant: lsu=%b alu=%b required 1/0", lsu_ready, alu_ready);
        end
        tick();
        alu_valid = 1'b0; lsu_valid = 1'b0;
        tick();
    endtask

    task automatic test_single_alu();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        @(negedge clk);
        n_cmp++;
        if (alu_ready !== 1'b1) begin
            n_err++;
            $display("FAIL single_ready: alu_ready=%b required 1", alu_ready);
        end
        tick();
        alu_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL single_write: we=%b waddr=%0d wdata=%h required 1/5/deadbeef", rf_we, rf_waddr, rf_wdata);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (rf_we !== 1'b0) begin
            n_err++;
            $display("FAIL single_idle: rf_we=%b required 0", rf_we);
        end
    endtask

    task automatic test_contention();
        bit exp_lsu, prev_lsu;
        reset = 1'b0; alu_valid = 1'b0; lsu_valid = 1'b0;
        tick();
        reset = 1'b1;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
        lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h22;
        prev_lsu = 1'b0;
        for (int i = 0; i < 4; i++) begin
`ifdef WB_ROUND_ROBIN_EN
            exp_lsu = (i % 2 == 0);
`else
            exp_lsu = 1'b1;
`endif
            @(negedge clk);
            n_cmp++;
            if (lsu_ready !== exp_lsu || alu_ready !== !exp_lsu) begin
                n_err++;
                $display("FAIL contention_grant%0d: lsu=%b alu=%b required %b/%b", i, lsu_ready, alu_ready, exp_lsu, !exp_lsu);
            end
            if (i > 0) begin
                n_cmp++;
                if (rf_we !== 1'b1 || rf_waddr !== (prev_lsu ? 5'd4 : 5'd3) || rf_wdata !== (prev_lsu ? 32'h22 : 32'h11)) begin
                    n_err++;
                    $display("FAIL contention_out%0d: we=%b waddr=%0d wdata=%h", i, rf_we, rf_waddr, rf_wdata);
                end
            end
            prev_lsu = exp_lsu;
            tick();
        end
        alu_valid = 1'b0; lsu_valid = 1'b0;
        tick();
    endtask

    task automatic test_raw();
        issue_valid = 1'b1; issue_rd = 5'd7; rs1 = 5'd7;
        @(negedge clk);
        n_cmp++;
        if (hazard_rs1 !== 1'b0) begin
            n_err++;
            $display("FAIL raw_before: hazard_rs1=%b required 0", hazard_rs1);
        end
        tick();
        issue_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (hazard_rs1 !== 1'b1) begin
            n_err++;
            $display("FAIL raw_set: hazard_rs1=%b required 1", hazard_rs1);
        end
        tick();
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
        @(negedge clk);
        n_cmp++;
        if (alu_ready !== 1'b1 || hazard_rs1 !== 1'b1) begin
            n_err++;
            $display("FAIL raw_accept: ready=%b hazard=%b required 1/1", alu_ready, hazard_rs1);
        end
        tick();
        alu_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || hazard_rs1 !== 1'b1) begin
            n_err++;
            $display("FAIL raw_commit: we=%b waddr=%0d hazard=%b required 1/7/1", rf_we, rf_waddr, hazard_rs1);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (hazard_rs1 !== 1'b0 || rf_we !== 1'b0) begin
            n_err++;
            $display("FAIL raw_clear: hazard=%b we=%b required 0/0", hazard_rs1, rf_we);
        end
    endtask

    task automatic test_same_cycle();
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
        tick();
        alu_valid = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd9;
        @(negedge clk);
        n_cmp++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || issue_stall !== 1'b0) begin
            n_err++;
            $display("FAIL same_pre: we=%b waddr=%0d stall=%b required 1/9/0", rf_we, rf_waddr, issue_stall);
        end
        tick();
        issue_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (issue_stall !== 1'b1) begin
            n_err++;
            $display("FAIL same_set_wins: issue_stall=%b required 1", issue_stall);
        end
        alu_valid = 1'b1;
        tick();
        alu_valid = 1'b0;
        tick();
    endtask

    task automatic test_rd0_midreset();
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h55; rs1 = 5'd0;
        @(negedge clk);
        n_cmp++;
        if (lsu_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rd0_ready: lsu_ready=%b required 1", lsu_ready);
        end
        tick();
        lsu_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (rf_we !== 1'b0 || hazard_rs1 !== 1'b0) begin
            n_err++;
            $display("FAIL rd0_nowrite: we=%b hazard=%b required 0/0", rf_we, hazard_rs1);
        end
        issue_valid = 1'b1; issue_rd = 5'd12; rs1 = 5'd12;
        tick();
        issue_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'hC0FFEE;
        tick();
        alu_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (rf_we !== 1'b1 || hazard_rs1 !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_pre: we=%b hazard=%b required 1/1", rf_we, hazard_rs1);
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (rf_we !== 1'b0 || rf_waddr !== '0 || rf_wdata !== '0 || hazard_rs1 !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_post: we=%b waddr=%0d wdata=%h hazard=%b required 0/0/0/0", rf_we, rf_waddr, rf_wdata, hazard_rs1);
        end
        tick();
    endtask

    task automatic test_random();
        bit ga, gl;
        for (int i = 0; i < 600; i++) begin
            if (!alu_valid && $urandom_range(0, 2) != 0) begin
                alu_valid = 1'b1; alu_rd = AW'($urandom_range(0, 31)); alu_data = $urandom;
            end
            if (!lsu_valid && $urandom_range(0, 2) != 0) begin
                lsu_valid = 1'b1; lsu_rd = AW'($urandom_range(0, 31)); lsu_data = $urandom;
            end
            issue_rd    = AW'($urandom_range(0, 31));
            issue_valid = ($urandom_range(0, 2) == 0) && !mdl_busy[issue_rd];
            rs1         = AW'($urandom_range(0, 31));
            rs2         = AW'($urandom_range(0, 31));
            reset       = ($urandom_range(0, 99) != 0);
            @(negedge clk);
            model_grant(ga, gl);
            n_cmp++;
            if (alu_ready !== ga || lsu_ready !== gl) begin
                n_err++;
                $display("FAIL rand_grant@%0d: alu=%b lsu=%b required %b/%b", i, alu_ready, lsu_ready, ga, gl);
            end
            n_cmp++;
            if (hazard_rs1 !== mdl_busy[rs1] || hazard_rs2 !== mdl_busy[rs2] || issue_stall !== mdl_busy[issue_rd]) begin
                n_err++;
                $display("FAIL rand_hazard@%0d: %b%b%b required %b%b%b", i, hazard_rs1, hazard_rs2, issue_stall,
                         mdl_busy[rs1], mdl_busy[rs2], mdl_busy[issue_rd]);
            end
            n_cmp++;
            if (rf_we !== mdl_we || (mdl_we && (rf_waddr !== mdl_waddr || rf_wdata !== mdl_wdata))) begin
                n_err++;
                $display("FAIL rand_out@%0d: we=%b waddr=%0d wdata=%h required %b/%0d/%h", i, rf_we, rf_waddr, rf_wdata,
                         mdl_we, mdl_waddr, mdl_wdata);
            end
            tick();
            if (ga) alu_valid = 1'b0;
            if (gl) lsu_valid = 1'b0;
        end
        reset = 1'b1; alu_valid = 1'b0; lsu_valid = 1'b0; issue_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_alu();
        test_contention();
        test_raw();
        test_same_cycle();
        test_rd0_midreset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Arbitrates the register file's single write port between two writeback requesters: the ALU and the load unit (LSU).
- Drives the register file's regWrite/A3/WD inputs from a registered output stage.
- Keeps a per-register pending-write scoreboard so decode can stall on RAW and WAW hazards before reading RS1/RS2.
- Sits between the execute/memory stages and the register file.

Parameters:
- XLEN, 32, data width of WD and requester data.
- AW, 5, register address width.
- NREG, 32, number of architectural registers (2**AW).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- alu_valid  in  1  ALU writeback request.
- alu_rd  in  AW  ALU destination register.
- alu_data  in  XLEN  ALU result.
- alu_ready  out  1  ALU request accepted this cycle.
- lsu_valid  in  1  LSU writeback request.
- lsu_rd  in  AW  LSU destination register.
- lsu_data  in  XLEN  load data.
- lsu_ready  out  1  LSU request accepted this cycle.
- issue_valid  in  1  decode issues an instruction that writes issue_rd.
- issue_rd  in  AW  destination of issuing instruction.
- rs1, rs2  in  AW  source registers being read by decode.
- hazard_rs1, hazard_rs2  out  1  source has a pending write.
- issue_stall  out  1  issue_rd already has a pending write (WAW).
- rf_we  out  1  to register file regWrite.
- rf_waddr  out  AW  to register file A3.
- rf_wdata  out  XLEN  to register file WD.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (reset==0 at posedge):
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - All busy bits cleared.
  - Round-robin pointer set to prefer LSU.
  - Pending requests are dropped; requesters must re-present them.
  - Applies identically when asserted mid-operation.
- Handshake:
  - A request is accepted when valid && ready.
  - ready is combinational from valid and arbitration state; it never depends on the requester's own ready.
  - A requester holds valid/rd/data stable until accepted.
  - At most one ready per cycle.
  - When exactly one requester is valid, it is granted immediately.
  - The output stage never back-pressures.
- Arbitration (both valid): fixed priority, LSU wins. See Optional Feature.
- Latency:
  - Request accepted in cycle N → rf_we=1 with rd/data during cycle N+1.
  - The register file captures the value at the end of N+1.
  - rf_we=0 in any cycle following a cycle with no acceptance.
- rd==0: the request is accepted (ready=1), rf_we stays 0, and no scoreboard effect occurs.
- Scoreboard:
  - busy[NREG-1:1]; busy[0] is constant 0.
  - Set: at posedge when issue_valid && issue_rd!=0.
  - Clear: at posedge ending a cycle with rf_we && rf_waddr==r.
  - Simultaneous set and clear of the same register: set wins.
  - Registers in the output stage stay busy until their write commits, so decode reading in N+2 sees the new value.
- Hazard outputs:
  - hazard_rs1 = busy[rs1]; hazard_rs2 = busy[rs2]; issue_stall = busy[issue_rd].
  - All are combinational; rs==0 always yields 0.
- Issuing while issue_stall=1 is a protocol violation. Defined result: the bit stays set and is cleared at the first matching writeback.
- Widths: no arithmetic; addresses compared at full AW bits.

Optional Feature:
- Macro: WB_ROUND_ROBIN_EN.
- Defined:
  - When both requesters are valid, grant the one not granted last.
  - A 1-bit pointer updates only on a contended grant.
  - Reset prefers LSU.
- Undefined:
  - Fixed priority, LSU always wins.
  - The ALU may starve; upstream guarantees LSU gaps.

Decomposition:
- Shared package wb_pkg:
  - XLEN and AW constants.
  - Requester enum {REQ_ALU, REQ_LSU}.
  - Writeback record typedef {we, waddr, wdata}.
- Sub-module wb_scoreboard: busy array, set/clear logic and three hazard lookups.
- Arbitration and output register stay in the top.

Test Plan:
- Reset: hold reset=0 two cycles with both valid → rf_we=0, both ready=0 during reset, all hazards 0; first cycle after release grants LSU.
- Single ALU write: alu_valid, rd=5, data=0xDEADBEEF in cycle N → alu_ready=1 in N; rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF in N+1; rf_we=0 in N+2.
- Contention:
  - Both valid (ALU rd=3/0x11, LSU rd=4/0x22) for 4 cycles.
  - Without macro: LSU granted every cycle.
  - With WB_ROUND_ROBIN_EN: grants LSU, ALU, LSU, ALU.
- Scoreboard RAW: issue rd=7 → hazard_rs1=1 for rs1=7 until the writeback of rd=7 commits, then 0 the cycle after rf_we.
- Same-cycle set and clear: writeback of rd=9 commits while issue rd=9 → busy[9] stays 1; issue_stall=1 for issue_rd=9 next cycle.
- rd=0 and mid-operation reset:
  - LSU write to rd=0 → lsu_ready=1, rf_we stays 0, hazard_rs1(rs1=0)=0.
  - reset=0 while busy[12]=1 and a write is in the output stage → busy cleared and rf_we=0 next cycle.
